// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, default datapath sizes and the
// reservation-station entry layout used by the execution units.
package cpu_pkg;

  localparam int DEF_RS_SIZE    = 4;
  localparam int DEF_REG_BIT    = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  // Entry layout at the default sizes; parameterised stations mirror it.
  typedef struct packed {
    logic                      busy;
    alu_op_e                   op;
    logic [DEF_DATA_WIDTH-1:0] vj;
    logic [DEF_DATA_WIDTH-1:0] vk;
    logic                      qj_busy;
    logic                      qk_busy;
    logic [DEF_REG_BIT-1:0]    qj;
    logic [DEF_REG_BIT-1:0]    qk;
    logic [DEF_REG_BIT-1:0]    dest;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the first set
// request bit and whether any bit was set.
module rs_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until both operands arrive
// (directly or via CDB snoop), then dispatches one ready op per cycle.
module alu_rs
  import cpu_pkg::*;
#(
  parameter int RS_SIZE    = DEF_RS_SIZE,
  parameter int REG_BIT    = DEF_REG_BIT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_en,
  input  alu_op_e               issue_op,
  input  logic [DATA_WIDTH-1:0] issue_vj,
  input  logic [DATA_WIDTH-1:0] issue_vk,
  input  logic                  issue_qj_busy,
  input  logic                  issue_qk_busy,
  input  logic [REG_BIT-1:0]    issue_qj,
  input  logic [REG_BIT-1:0]    issue_qk,
  input  logic [REG_BIT-1:0]    issue_dest,
  output logic                  rs_full,
  input  logic                  cdb_en,
  input  logic [REG_BIT-1:0]    cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  alu_en,
  output alu_op_e               alu_ins_type,
  output logic [DATA_WIDTH-1:0] alu_lhs,
  output logic [DATA_WIDTH-1:0] alu_rhs,
  output logic [REG_BIT-1:0]    alu_dest
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                  busy;
    alu_op_e               op;
    logic [DATA_WIDTH-1:0] vj;
    logic [DATA_WIDTH-1:0] vk;
    logic                  qj_busy;
    logic                  qk_busy;
    logic [REG_BIT-1:0]    qj;
    logic [REG_BIT-1:0]    qk;
    logic [REG_BIT-1:0]    dest;
  } entry_t;

  entry_t ent_reg  [RS_SIZE];
  entry_t ent_next [RS_SIZE];
  entry_t issue_entry;

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_now;
  logic [RS_SIZE-1:0] ready_reg;
  logic [IDX_W-1:0]   alloc_idx;
  logic               alloc_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               do_issue;

  logic                  alu_en_reg;
  alu_op_e               alu_op_reg;
  logic [DATA_WIDTH-1:0] alu_lhs_reg;
  logic [DATA_WIDTH-1:0] alu_rhs_reg;
  logic [REG_BIT-1:0]    alu_dest_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_flags
      assign busy_vec[gi]  = ent_reg[gi].busy;
      assign ready_now[gi] = ent_reg[gi].busy & ~ent_reg[gi].qj_busy & ~ent_reg[gi].qk_busy;
    end
  endgenerate

  assign rs_full  = &busy_vec;
  assign do_issue = issue_en & ~rs_full & ~flush & alloc_valid;

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_alloc_enc (
    .req   (~busy_vec),
    .idx   (alloc_idx),
    .valid (alloc_valid)
  );

  // Selection uses last cycle's readiness, masked by current busy so an entry
  // dispatched on the previous edge cannot be picked twice.
  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_sel_enc (
    .req   (ready_reg & busy_vec),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    issue_entry         = '0;
    issue_entry.busy    = 1'b1;
    issue_entry.op      = issue_op;
    issue_entry.vj      = issue_vj;
    issue_entry.vk      = issue_vk;
    issue_entry.qj_busy = issue_qj_busy;
    issue_entry.qk_busy = issue_qk_busy;
    issue_entry.qj      = issue_qj;
    issue_entry.qk      = issue_qk;
    issue_entry.dest    = issue_dest;
    if (cdb_en && issue_qj_busy && issue_qj == cdb_tag) begin
      issue_entry.vj      = cdb_data;
      issue_entry.qj_busy = 1'b0;
    end
    if (cdb_en && issue_qk_busy && issue_qk == cdb_tag) begin
      issue_entry.vk      = cdb_data;
      issue_entry.qk_busy = 1'b0;
    end
  end

  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      always_comb begin
        ent_next[gi] = ent_reg[gi];
        if (ent_reg[gi].busy && cdb_en) begin
          if (ent_reg[gi].qj_busy && ent_reg[gi].qj == cdb_tag) begin
            ent_next[gi].vj      = cdb_data;
            ent_next[gi].qj_busy = 1'b0;
          end
          if (ent_reg[gi].qk_busy && ent_reg[gi].qk == cdb_tag) begin
            ent_next[gi].vk      = cdb_data;
            ent_next[gi].qk_busy = 1'b0;
          end
        end
        if (sel_valid && sel_idx == IDX_W'(gi)) ent_next[gi].busy = 1'b0;
        if (do_issue && alloc_idx == IDX_W'(gi)) ent_next[gi] = issue_entry;
        if (flush) ent_next[gi].busy = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_reg[i].busy <= 1'b0;
      ready_reg    <= '0;
      alu_en_reg   <= 1'b0;
      alu_op_reg   <= ALU_ADD;
      alu_lhs_reg  <= '0;
      alu_rhs_reg  <= '0;
      alu_dest_reg <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent_reg[i] <= ent_next[i];
      ready_reg  <= flush ? '0 : ready_now;
      alu_en_reg <= sel_valid & ~flush;
      if (sel_valid && !flush) begin
        alu_op_reg   <= ent_reg[sel_idx].op;
        alu_lhs_reg  <= ent_reg[sel_idx].vj;
        alu_rhs_reg  <= ent_reg[sel_idx].vk;
        alu_dest_reg <= ent_reg[sel_idx].dest;
      end
    end
  end

  assign alu_en       = alu_en_reg;
  assign alu_ins_type = alu_op_reg;
  assign alu_lhs      = alu_lhs_reg;
  assign alu_rhs      = alu_rhs_reg;
  assign alu_dest     = alu_dest_reg;

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station feeding the ALU execution unit. It accepts issued ALU instructions from the decoder/issue stage and holds them until both operands are valid. Operands are captured by snooping the common data bus (CDB). Each cycle it dispatches at most one ready instruction to `alu` as a registered, one-cycle pulse.

## Interface
- `RS_SIZE`, 4: number of entries; power of two, 2..16.
- `REG_BIT`, 5: tag width (ROB id carried on CDB).
- `DATA_WIDTH`, 32: operand/data width.

- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `flush` in 1: misprediction clear; drops all entries.
- `issue_en` in 1: issue valid this cycle.
- `issue_op` in 3: ALU operation code (shared package enum).
- `issue_vj`, `issue_vk` in DATA_WIDTH: operand values when ready.
- `issue_qj_busy`, `issue_qk_busy` in 1: 1 = operand not yet produced, wait on tag.
- `issue_qj`, `issue_qk` in REG_BIT: producer tags.
- `issue_dest` in REG_BIT: destination tag of this instruction.
- `rs_full` out 1: all entries busy; combinational from busy bits.
- `cdb_en` in 1: CDB broadcast valid.
- `cdb_tag` in REG_BIT: broadcast tag.
- `cdb_data` in DATA_WIDTH: broadcast value.
- `alu_en` out 1: dispatch pulse to ALU.
- `alu_ins_type` out 3, `alu_lhs` out DATA_WIDTH, `alu_rhs` out DATA_WIDTH, `alu_dest` out REG_BIT: dispatched op, operands, tag.

## Operation
- Entry fields: `busy`, `op`, `vj`, `vk`, `qj_busy`, `qk_busy`, `qj`, `qk`, `dest`.
- Issue: when `issue_en && !rs_full && !flush`, write the lowest-index free entry and set `busy`=1.
- Issue-time CDB bypass: if `cdb_en` and an issued operand is busy with tag == `cdb_tag`, store `cdb_data` in that operand and clear its busy flag.
- `issue_en` while `rs_full`=1 is an upstream protocol violation. The issue is dropped and state is unchanged.
- CDB snoop: every busy entry with `qX_busy && qX == cdb_tag && cdb_en` captures `cdb_data` into `vX` and clears `qX_busy`. The j and k operands are matched independently; both may match the same broadcast.
- Ready: `busy && !qj_busy && !qk_busy`, evaluated on registered state.
- An operand that wakes via CDB in cycle N is eligible for selection in cycle N+1.
- Dispatch: the lowest-index ready entry is selected. The next edge registers `alu_en`=1 with its op/vj/vk/dest and clears that entry's `busy`.
- With no ready entry, `alu_en`=0 and the other alu_* outputs hold their last value.
- A slot freed by dispatch in cycle N is not allocatable until N+1.
- Issue and dispatch in the same cycle always target different entries.
- `flush`: next edge clears every `busy` and drives `alu_en`=0. Flush overrides same-cycle issue, dispatch and snoop.
- Reset (`rst`=0 at edge): all `busy`=0, `alu_en`=0, `alu_ins_type`=0, `alu_lhs`=0, `alu_rhs`=0, `alu_dest`=0. `rs_full` is therefore 0.
- Reset asserted mid-operation discards all entries, the same as flush.

## Timing
- Issue at edge N: entry visible at N+1.
- If both operands are ready at issue, select occurs in cycle N+1 and `alu_en` is high after edge N+2, so minimum issue-to-ALU latency is 2 cycles.
- CDB wake at edge N (broadcast sampled): select in cycle N+1, `alu_en` high after edge N+2.
- `alu_en` is high for exactly one cycle per dispatched entry. With multiple ready entries it is high on consecutive cycles (throughput 1/cycle).
- `rs_full` is combinational from registered `busy`. It deasserts in the cycle after the dispatch edge that freed a slot.
- No backpressure from the ALU: the ALU accepts every `alu_en` pulse.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU op enum (3-bit: ADD, SUB, AND, OR, XOR, SLL, SRL, SLT);
  - `RS_SIZE`, `REG_BIT` and `DATA_WIDTH` defaults;
  - the RS entry struct typedef.
- Sub-module `rs_prio_enc`: parameterised lowest-index priority encoder (request vector → index + valid).
  - Instantiated twice: once for free-slot allocation, once for ready selection.

## Test plan
- Issue ADD, vj=5, vk=7, both ready, dest=3 at edge 0 → `alu_en`=1 after edge 2 with lhs=5, rhs=7, dest=3. Pulse lasts one cycle and the entry frees.
- Issue op with qj_busy, qj=9. Broadcast cdb_tag=9, data=0x1234 at edge 4 → `alu_lhs`=0x1234, `alu_en`=1 after edge 6.
- Issue with qj=qk=2, both busy, in the same cycle as cdb_tag=2, data=0xAA → both operands captured (bypass), dispatch with lhs=rhs=0xAA two cycles later.
- Fill 4 entries all waiting on tag 1 → `rs_full`=1, and a 5th issue is ignored. Broadcast tag 1 → dispatches in entry order 0,1,2,3 on consecutive cycles, and `rs_full`=0 one cycle after the first dispatch.
- Two ready entries plus `flush` asserted → next cycle `alu_en`=0, `rs_full`=0, no dispatch ever occurs for them.
- Hold `rst`=0 for one edge mid-stream with 3 busy entries → all alu_* outputs are 0 and no dispatch follows until new issues arrive.
